// File: rtl/audio_sample_sync.sv
// Audio sample-rate generator and decimator: derives a sample-rate clock, reduces 18-bit
// core audio to 16-bit volume-scaled samples. Optional boxcar averaging under AUDIO_BOXCAR_EN.
module audio_sample_sync #(
    parameter int unsigned CLK_HZ      = 31500000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned AVG_LOG2    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] audio_l,
    input  logic [17:0] audio_r,
    input  logic [1:0]  volume,
    output logic        clk_audio,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic        sample_valid
);

    localparam int unsigned N     = CLK_HZ / SAMPLE_RATE;
    localparam int unsigned H     = N / 2;
    localparam int unsigned WIN   = 2 ** AVG_LOG2;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W = 18 + AVG_LOG2;

    // The averaging window must close before the load point.
    generate
        if (WIN > H) begin : g_bad_cfg
            $error("audio_sample_sync: 2**AVG_LOG2 exceeds half the sample period");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_audio_q, clk_audio_d;
    logic             valid_q, valid_d;
    logic [15:0]      sample_l_q, sample_l_d;
    logic [15:0]      sample_r_q, sample_r_d;
    logic [17:0]      avg_l, avg_r;
    logic             load_c;

    function automatic logic [15:0] apply_volume(input logic [15:0] base, input logic [1:0] vol);
        case (vol)
            2'd0:    return 16'h0000;
            2'd1:    return {{2{base[15]}}, base[15:2]};
            2'd2:    return {base[15], base[15:1]};
            default: return base;
        endcase
    endfunction

    assign load_c = (cnt_q == CNT_W'(H));

`ifdef AUDIO_BOXCAR_EN
    logic [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [ACC_W-1:0] ext_l, ext_r;
    logic             unused_acc;

    assign ext_l = {{AVG_LOG2{audio_l[17]}}, audio_l};
    assign ext_r = {{AVG_LOG2{audio_r[17]}}, audio_r};

    // Window restarts on cnt==0 so nothing carries from the previous period.
    always_comb begin
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (cnt_q < CNT_W'(WIN)) begin
            if (cnt_q == '0) begin
                acc_l_d = ext_l;
                acc_r_d = ext_r;
            end else begin
                acc_l_d = acc_l_q + ext_l;
                acc_r_d = acc_r_q + ext_r;
            end
        end
    end

    assign avg_l      = acc_l_q[ACC_W-1:AVG_LOG2];
    assign avg_r      = acc_r_q[ACC_W-1:AVG_LOG2];
    assign unused_acc = ^{acc_l_q[AVG_LOG2-1:0], acc_r_q[AVG_LOG2-1:0]};
`else
    assign avg_l = audio_l;
    assign avg_r = audio_r;
`endif

    logic unused_avg;
    assign unused_avg = ^{avg_l[1:0], avg_r[1:0]};

    always_comb begin
        cnt_d       = (cnt_q == CNT_W'(N - 1)) ? '0 : cnt_q + CNT_W'(1);
        clk_audio_d = (cnt_q < CNT_W'(H));
        valid_d     = load_c;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        if (load_c) begin
            sample_l_d = apply_volume(avg_l[17:2], volume);
            sample_r_d = apply_volume(avg_r[17:2], volume);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            clk_audio_q <= 1'b0;
            valid_q     <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
`ifdef AUDIO_BOXCAR_EN
            acc_l_q     <= '0;
            acc_r_q     <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            clk_audio_q <= clk_audio_d;
            valid_q     <= valid_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
`ifdef AUDIO_BOXCAR_EN
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
`endif
        end
    end

    assign clk_audio    = clk_audio_q;
    assign sample_valid = valid_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;

endmodule

// File: doc/audio_sample_sync.md
AUDIO_SAMPLE_SYNC -- requirements
Module: audio_sample_sync

Interface
REQ-001 SHALL have parameter CLK_HZ, default 31500000, pixel/system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, output audio sample rate in Hz.
REQ-003 SHALL have parameter AVG_LOG2, default 8, log2 of the boxcar averaging window length.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port audio_l, input, 18, signed left core audio.
REQ-007 SHALL have port audio_r, input, 18, signed right core audio.
REQ-008 SHALL have port volume, input, 2, level select: 0 mute, 1 quarter, 2 half, 3 full.
REQ-009 SHALL have port clk_audio, output, 1, sample-rate square wave for the HDMI audio clock input.
REQ-010 SHALL have port sample_l, output, 16, signed left sample.
REQ-011 SHALL have port sample_r, output, 16, signed right sample.
REQ-012 SHALL have port sample_valid, output, 1, one-cycle pulse when new sample_l/sample_r are loaded.

Function
REQ-013 SHALL derive N = CLK_HZ/SAMPLE_RATE (integer truncation) and H = N/2 (truncation); N=656, H=328 at defaults.
REQ-014 SHALL run phase counter cnt: counts 0..N-1 and wraps N-1 -> 0 every cycle outside reset.
REQ-015 SHALL register clk_audio = (cnt < H) every cycle, so it lags cnt by one cycle (high H cycles, low N-H cycles).
REQ-016 SHALL, per channel, sum the sign-extended input into an accumulator of width 18+AVG_LOG2 on cycles with cnt in 0..2^AVG_LOG2-1.
REQ-017 SHALL start the accumulator with the cnt=0 sample; the previous sum is discarded with no carry between windows.
REQ-018 SHALL ignore inputs on cycles with cnt >= 2^AVG_LOG2.
REQ-019 SHALL form avg = accumulator arithmetic-shifted right by AVG_LOG2 (18-bit signed).
REQ-020 SHALL form base = avg arithmetic-shifted right by 2 (16-bit signed); no saturation is needed since the range is exact.
REQ-021 SHALL apply volume to base using the volume value sampled only on the load cycle: 0 -> 0; 1 -> base>>>2; 2 -> base>>>1; 3 -> base.
REQ-022 SHALL load sample_l/sample_r on the clock edge where cnt==H, and pulse sample_valid high for exactly the following cycle.
REQ-023 SHALL hold the outputs stable otherwise, so the outputs change coincident with clk_audio falling and are stable across its rising edge.
REQ-024 SHALL NOT affect the current output word when volume changes between loads.
REQ-025 SHALL treat 2^AVG_LOG2 > H as an illegal configuration, flagged by an elaboration-time error.

Reset
REQ-026 SHALL, while reset_n=0 at a clk edge, set cnt=0, clear both accumulators, and drive clk_audio=0, sample_l=0, sample_r=0, sample_valid=0.
REQ-027 SHALL, on reset asserted mid-window, abandon the partial sum; no sample_valid occurs until the cnt==H load of the first post-reset window.
REQ-028 SHALL have the first post-reset cycle with reset_n=1 begin at cnt=0.

Configuration
REQ-029 SHALL use macro AUDIO_BOXCAR_EN: when defined, averaging per REQ-016..REQ-019 is compiled in.
REQ-030 SHALL, without AUDIO_BOXCAR_EN, compile out the accumulators and use avg = input sampled on the cnt==H load edge (point decimation), with all other behaviour identical.

Verification (CLK_HZ=31500000, AVG_LOG2=8, AUDIO_BOXCAR_EN defined unless stated)
REQ-031 SHALL cover: reset_n=0 for 5 cycles with inputs nonzero -> clk_audio, sample_l, sample_r, sample_valid all 0; first valid pulse 329 cycles after release.
REQ-032 SHALL cover: audio_l=18'h10000, audio_r=18'h3FFFC constant, volume=3 -> sample_l=16'h4000, sample_r=16'hFFFF.
REQ-033 SHALL cover: audio_l=18'h1FFFF constant, volume 3/2/1/0 -> sample_l 16'h7FFF / 16'h3FFF / 16'h1FFF / 16'h0000.
REQ-034 SHALL cover: audio_l=4000 for cnt 0..127, 0 for 128..255, 18'h1FFFF after, volume=3 -> sample_l=500 (16'h01F4); without macro -> 16'h7FFF.
REQ-035 SHALL cover: free run 10 periods -> clk_audio period 656, high 328; sample_valid once per 656 cycles, in the cycle clk_audio first reads 0.
REQ-036 SHALL cover: reset_n pulsed low at cnt=200 -> outputs 0; next sample_valid 329 cycles after release; value reflects the post-reset window only.
